// File: rtl/dco_freq_meter_if.sv
`default_nettype none
// ============================================================================
// Module : dco_freq_meter_if
// Brief  : Control/result bundle between a DCO frequency meter and its host
// Rev    : 1.0  initial release
// ============================================================================
interface dco_freq_meter_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             continuous;
  logic             busy;
  logic [CNT_W-1:0] count_out;
  logic             count_valid;
  logic             overflow;

  modport master (
    output start,
    output continuous,
    input  busy,
    input  count_out,
    input  count_valid,
    input  overflow
  );

  modport slave (
    input  start,
    input  continuous,
    output busy,
    output count_out,
    output count_valid,
    output overflow
  );
endinterface
`default_nettype wire

// File: rtl/dco_freq_meter.sv
`default_nettype none
// ============================================================================
// Module : dco_freq_meter
// Brief  : Counts synchronized DCO rising edges over a fixed clk gate window
// Rev    : 1.0  initial release
// ============================================================================
module dco_freq_meter #(
  parameter int GATE_CYCLES = 256,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic            osc_in,
  dco_freq_meter_if.slave mif
);

  localparam int               GATE_W    = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [GATE_W-1:0] GATE_ONE  = GATE_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   osc_s;
  logic                   osc_prev;
  logic                   rise;

  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic [CNT_W-1:0]  edge_next;
  logic              sat;
  logic              sat_next;
  logic              gate_last;
  logic              measuring;
  logic              publish;

  logic [CNT_W-1:0]  count_q;
  logic              valid_q;
  logic              ovf_q;

  // Synchronizer and edge detector run in every state so ARM sees a settled osc_prev.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      osc_prev <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], osc_in};
      osc_prev <= osc_s;
    end
  end

  assign osc_s     = sync_q[SYNC_STAGES-1];
  assign rise      = osc_s & ~osc_prev;
  assign measuring = (state == MEASURE);
  assign gate_last = (gate_cnt == GATE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mif.start) state_next = ARM;
      ARM:     state_next = MEASURE;
      MEASURE: if (gate_last) state_next = DONE;
      DONE:    state_next = mif.continuous ? ARM : IDLE;
      default: state_next = IDLE;
    endcase
    if (!ena) begin
      state_next = IDLE;
    end
  end

  // The final MEASURE cycle's edge must be included, so the published value is
  // taken from the next-count path rather than the registered counter.
  always_comb begin
    edge_next = edge_cnt;
    sat_next  = sat;
    if (measuring && rise) begin
      if (edge_cnt == CNT_MAX) begin
        sat_next = 1'b1;
      end else begin
        edge_next = edge_cnt + CNT_ONE;
      end
    end
  end

  assign publish = measuring && gate_last && ena;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat      <= 1'b0;
    end else if (!ena || !measuring) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat      <= 1'b0;
    end else begin
      gate_cnt <= gate_cnt + GATE_ONE;
      edge_cnt <= edge_next;
      sat      <= sat_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= publish;
      if (publish) begin
        count_q <= edge_next;
        ovf_q   <= sat_next;
      end
    end
  end

  assign mif.busy        = (state != IDLE);
  assign mif.count_out   = count_q;
  assign mif.count_valid = valid_q;
  assign mif.overflow    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_dco_freq_meter.sv
`default_nettype none
// ============================================================================
// Module : tb_dco_freq_meter
// Brief  : Scoreboard bench for dco_freq_meter (256- and 1024-cycle gates)
// Rev    : 1.0  initial release
// ============================================================================
module tb_dco_freq_meter;

  localparam int G0 = 256;
  localparam int G1 = 1024;

  typedef struct {
    int cnt;
    bit ovf;
    int cyc;
  } exp_t;

  typedef struct {
    int period;
    bit level;
    bit big;
    int exp_cnt;
    bit exp_ovf;
  } vec_t;

  logic clk;
  logic rst_n;
  logic ena;
  logic osc_in;

  int osc_period;
  bit osc_level;
  int osc_ph;
  int cyc;
  int checks;
  int errors;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0;
  exp_t e1;

  dco_freq_meter_if #(.CNT_W(8)) bus0 ();
  dco_freq_meter_if #(.CNT_W(8)) bus1 ();

  dco_freq_meter #(.GATE_CYCLES(G0), .CNT_W(8), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc_in), .mif(bus0)
  );

  dco_freq_meter #(.GATE_CYCLES(G1), .CNT_W(8), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc_in), .mif(bus1)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc++;

  // Oscillator model: changes a few ns after clk, i.e. asynchronously to it.
  always @(posedge clk) begin
    #3;
    if (osc_period == 0) begin
      osc_in = osc_level;
    end else begin
      osc_ph = (osc_ph + 1) % osc_period;
      osc_in = (osc_ph < osc_period / 2);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus0.count_valid) begin
      if (q0.size() == 0) begin
        check("unexpected_valid0", 1, 0);
      end else begin
        e0 = q0.pop_front();
        check("count0", int'(bus0.count_out), e0.cnt);
        check("ovf0", int'(bus0.overflow), int'(e0.ovf));
        check("latency0", cyc, e0.cyc);
      end
    end
    if (bus1.count_valid) begin
      if (q1.size() == 0) begin
        check("unexpected_valid1", 1, 0);
      end else begin
        e1 = q1.pop_front();
        check("count1", int'(bus1.count_out), e1.cnt);
        check("ovf1", int'(bus1.overflow), int'(e1.ovf));
        check("latency1", cyc, e1.cyc);
      end
    end
  end

  // Start is sampled on the next edge (cyc+1); the result appears after
  // edge cyc+1+1+G, and is seen at the negedge when cyc has that value.
  task automatic pulse_start(input bit big, input int cnt, input bit ovf,
                             input int repeats);
    int g;
    exp_t e;
    g = big ? G1 : G0;
    @(posedge clk); #1;
    for (int i = 0; i < repeats; i++) begin
      e.cnt = cnt;
      e.ovf = ovf;
      e.cyc = cyc + 2 + g + i * (g + 2);
      if (big) q1.push_back(e); else q0.push_back(e);
    end
    if (big) bus1.start = 1'b1; else bus0.start = 1'b1;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk);
      if (!bus0.busy && !bus1.busy && q0.size() == 0 && q1.size() == 0) done = 1'b1;
    end
    check({name, "_idle_reached"}, int'(done), 1);
    repeat (3) @(negedge clk);
    check({name, "_busy0_low"}, int'(bus0.busy), 0);
    check({name, "_busy1_low"}, int'(bus1.busy), 0);
  endtask

  vec_t vecs[14];

  initial begin
    checks = 0; errors = 0; cyc = 0;
    osc_period = 0; osc_level = 1'b0; osc_ph = 0; osc_in = 1'b0;
    rst_n = 1'b0; ena = 1'b1;
    bus0.start = 1'b0; bus0.continuous = 1'b0;
    bus1.start = 1'b0; bus1.continuous = 1'b0;

    vecs[0]  = '{period: 4, level: 1'b0, big: 1'b0, exp_cnt: 64,  exp_ovf: 1'b0};
    vecs[1]  = '{period: 2, level: 1'b0, big: 1'b0, exp_cnt: 128, exp_ovf: 1'b0};
    for (int i = 2; i < 10; i++)
      vecs[i] = '{period: 8, level: 1'b1, big: 1'b0, exp_cnt: 32, exp_ovf: 1'b0};
    vecs[10] = '{period: 0, level: 1'b0, big: 1'b0, exp_cnt: 0,   exp_ovf: 1'b0};
    vecs[11] = '{period: 0, level: 1'b1, big: 1'b0, exp_cnt: 0,   exp_ovf: 1'b0};
    vecs[12] = '{period: 2, level: 1'b0, big: 1'b1, exp_cnt: 255, exp_ovf: 1'b1};
    vecs[13] = '{period: 8, level: 1'b0, big: 1'b1, exp_cnt: 128, exp_ovf: 1'b0};

    // Reset then idle
    repeat (5) begin
      @(negedge clk);
      check("rst_busy", int'(bus0.busy), 0);
      check("rst_count", int'(bus0.count_out), 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_busy", int'(bus0.busy), 0);
      check("idle_count", int'(bus0.count_out), 0);
      check("idle_valid", int'(bus0.count_valid), 0);
      check("idle_ovf", int'(bus0.overflow), 0);
    end

    // Table-driven single measurements
    for (int v = 0; v < 14; v++) begin
      if (vecs[v].period == 8 && !vecs[v].big) begin
        osc_period = 0; osc_level = 1'b1;
        repeat (10) @(posedge clk);
        osc_ph = $urandom_range(0, 7);
        osc_period = 8;
        repeat ($urandom_range(1, 8)) @(posedge clk);
      end else begin
        osc_ph = 0;
        osc_level = vecs[v].level;
        osc_period = vecs[v].period;
        repeat (10) @(posedge clk);
      end
      pulse_start(vecs[v].big, vecs[v].exp_cnt, vecs[v].exp_ovf, 1);
      wait_idle($sformatf("vec%0d", v));
    end

    // Continuous mode: three results, continuous dropped in the third window
    osc_ph = 0; osc_period = 4;
    repeat (5) @(posedge clk);
    bus0.continuous = 1'b1;
    pulse_start(1'b0, 64, 1'b0, 3);
    repeat (2 * G0 + 104) @(posedge clk);
    #1 bus0.continuous = 1'b0;
    wait_idle("continuous");
    repeat (300) @(negedge clk);
    check("cont_stays_idle", int'(bus0.busy), 0);

    // ena abort at MEASURE cycle ~100; a wrongly published result would be 128
    osc_period = 2;
    @(posedge clk); #1 bus0.start = 1'b1;
    @(posedge clk); #1 bus0.start = 1'b0;
    repeat (101) @(posedge clk);
    #1 ena = 1'b0;
    @(posedge clk); #1 ena = 1'b1;
    @(negedge clk);
    check("abort_busy", int'(bus0.busy), 0);
    repeat (300) @(negedge clk);
    check("abort_busy_later", int'(bus0.busy), 0);
    check("abort_count_held", int'(bus0.count_out), 64);
    check("abort_ovf_held", int'(bus0.overflow), 0);

    // start held high: exactly two back-to-back measurements (one IDLE cycle between)
    osc_ph = 0; osc_period = 4;
    repeat (4) @(posedge clk);
    @(posedge clk); #1;
    e0.cnt = 64; e0.ovf = 1'b0; e0.cyc = cyc + 2 + G0;
    q0.push_back(e0);
    e0.cyc = cyc + 2 + G0 + G0 + 3;
    q0.push_back(e0);
    bus0.start = 1'b1;
    repeat (G0 + 10) @(posedge clk);
    #1 bus0.start = 1'b0;
    wait_idle("start_held");

    // Asynchronous reset mid-MEASURE
    @(posedge clk); #1 bus0.start = 1'b1;
    @(posedge clk); #1 bus0.start = 1'b0;
    repeat (50) @(posedge clk);
    #5 rst_n = 1'b0;
    #1;
    check("arst_busy", int'(bus0.busy), 0);
    check("arst_count", int'(bus0.count_out), 0);
    check("arst_valid", int'(bus0.count_valid), 0);
    check("arst_ovf", int'(bus0.overflow), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (G0 + 20) @(negedge clk);
    check("post_rst_busy", int'(bus0.busy), 0);
    check("post_rst_count", int'(bus0.count_out), 0);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dco_freq_meter.md
Name: dco_freq_meter

Overview:
Measures the output frequency of the on-chip DCO. It counts synchronized rising edges of the oscillator signal over a fixed gate window of system-clock cycles, then reports the edge count as a code. This closes the loop on the DCO: the DCO converts code to frequency, and this block converts frequency back to code, for on-chip characterisation and calibration. It sits beside the DCO inside the tt_um top level. osc_in comes from the DCO output, and the results drive uo_out/uio_out.

Parameters:
GATE_CYCLES, 256, gate window length in clk cycles (>=2)
CNT_W, 8, width of edge counter and count_out
SYNC_STAGES, 2, flip-flop stages in the osc_in synchronizer (>=2)

Ports:
clk  input  1  system clock (50 MHz)
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; low aborts any measurement and forces IDLE
osc_in  input  1  DCO output, asynchronous to clk
start  input  1  level-sampled request; starts one measurement when sampled in IDLE
continuous  input  1  when 1, re-arms automatically after each result
busy  output  1  high in ARM, MEASURE and DONE
count_out  output  CNT_W  last completed edge count; held until the next completion
count_valid  output  1  one-cycle pulse when count_out updates
overflow  output  1  edge count saturated during the last completed measurement; updated with count_out

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, count_out=0, count_valid=0, overflow=0. Synchronizer, edge-detect register and all counters are cleared.
- Synchronizer: SYNC_STAGES flip-flops on osc_in; osc_s is the last stage.
- Edge detect: rise = osc_s & ~osc_prev, with osc_prev <= osc_s every cycle.
- Accuracy limit: correct only for osc_in period >= 2 clk cycles. Faster inputs alias, and no error is flagged.
- IDLE:
  - busy=0.
  - start=1 & ena=1 -> ARM.
- ARM (1 cycle):
  - Clear edge counter, gate counter and the internal sat flag.
  - rise is ignored, so an osc_in that is already high is not counted.
  - Next state: MEASURE.
- MEASURE (exactly GATE_CYCLES cycles):
  - Gate counter increments every cycle.
  - Each cycle with rise=1 increments the edge counter, including the final MEASURE cycle.
  - At 2^CNT_W-1 the edge counter holds, and a further rise sets sat.
  - When the gate counter reaches GATE_CYCLES-1 -> DONE.
- DONE (1 cycle):
  - count_out <= edge count; overflow <= sat; count_valid=1 for this cycle only.
  - Next state: continuous=1 -> ARM; otherwise -> IDLE.
- Latency: start sampled at edge N gives count_valid high in the cycle after edge N+1+GATE_CYCLES.
- Result period in continuous mode: GATE_CYCLES+2 cycles.
- start while busy is ignored; no queueing.
- continuous is sampled only in DONE. Dropping it mid-measurement lets the current measurement finish, then the block goes to IDLE.
- ena=0 in any state:
  - Next state is IDLE and counters clear.
  - count_out and overflow hold their old values.
  - No count_valid pulse.
  - ena=0 overrides a simultaneous start.
- Gate counter width: clog2(GATE_CYCLES). No wrap is possible because the state exits at GATE_CYCLES-1.
- count_valid is registered; count_out and overflow change only on the same edge that raises count_valid.
- Reset asserted mid-measurement: outputs return to reset values immediately; no partial result is ever published.

Test Plan:
1. Reset, then idle: rst_n=0 for 5 cycles, then release with start=0 -> busy=0, count_out=0x00, count_valid=0, overflow=0 held for 100 cycles.
2. Nominal count: GATE_CYCLES=256, osc_in period 4 clk (80 ns), pulse start for 1 cycle -> exactly one count_valid pulse, 258 cycles after start sampled; count_out=64; overflow=0; busy low afterwards. Repeat with osc_in period 2 clk -> 128.
3. Phase independence and static input:
   - osc_in held high before start, period 8 clk with random phase -> count_out=32 for every one of 8 trials.
   - osc_in stuck low or stuck high -> count_out=0.
4. Saturation: GATE_CYCLES=1024, osc_in period 2 clk -> count_out=255, overflow=1. Follow-up run at period 8 -> count_out=128, overflow=0.
5. Continuous mode: continuous=1, start pulsed once, osc_in period 4, GATE_CYCLES=256 -> count_valid pulses every 258 cycles with count_out=64 each time. Deassert continuous mid-window -> exactly one more pulse, then IDLE.
6. Abort paths:
   - ena=0 for 1 cycle at cycle 100 of MEASURE -> IDLE, no count_valid, count_out keeps its previous value.
   - rst_n pulsed low mid-MEASURE -> all outputs 0 asynchronously (checked before the next clk edge).
   - start held high throughout busy -> no extra measurement until IDLE is re-entered.
